// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : multi-cycle data-memory stage (lane align, req/ack, load extend)
// Rev 1.0 -- LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses
// ============================================================================
module load_store_unit #(
   parameter int ADDR_W   = 12,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              d_mem_wen_i,
   input  logic [3:0]        be_i,
   input  logic [2:0]        lfunct_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [4:0]        rd_wa_i,
   output logic              stall_o,
   output logic              ld_valid_o,
   output logic [31:0]       ld_data_o,
   output logic [4:0]        ld_wa_o,
   output logic              bus_err_o,
   output logic              misalign_o,
   output logic              mem_req_o,
   output logic              mem_wen_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_dout_o,
   input  logic [31:0]       mem_din_i,
   input  logic              mem_ack_i
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t            state_q;
   logic [7:0]        wait_cnt_q;
   logic              is_load_q;
   logic [2:0]        lfunct_q;
   logic [1:0]        lane_q;
   logic [4:0]        rd_wa_q;
   logic              ld_valid_q;
   logic              bus_err_q;
   logic [31:0]       ld_data_q;
   logic [4:0]        ld_wa_q;
   logic              mem_req_q;
   logic              mem_wen_q;
   logic [3:0]        mem_be_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_dout_q;

   logic [3:0]        be_shift;
   logic [31:0]       dout_shift;
   logic              is_half;
   logic              is_word;
   logic              misaligned;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data_d;

   assign be_shift   = be_i << addr_i[1:0];
   assign dout_shift = wdata_i << {addr_i[1:0], 3'b000};

   // Loads size by funct3 (bit1 set = word, incl. the undefined encodings); stores by mask.
   always_comb begin
      is_half = 1'b0;
      is_word = 1'b0;
      if (d_mem_wen_i) begin
         is_half = (lfunct_i[1:0] == 2'b01);
         is_word = lfunct_i[1];
      end else begin
         is_half = (be_i == 4'b0011);
         is_word = (be_i == 4'b1111);
      end
      misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
   end

   assign ld_byte = mem_din_i[{lane_q, 3'b000} +: 8];
   assign ld_half = lane_q[1] ? mem_din_i[31:16] : mem_din_i[15:0];

   always_comb begin
      ld_data_d = mem_din_i;
      case (lfunct_q)
         3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data_d = {24'd0, ld_byte};
         3'b101:  ld_data_d = {16'd0, ld_half};
         default: ld_data_d = mem_din_i;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_q;
   assign misalign_o = misalign_q;
`else
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
   assign misalign_o        = 1'b0;
`endif

   if (ADDR_W < 30) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[31:ADDR_W+2];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 8'd0;
         is_load_q  <= 1'b0;
         lfunct_q   <= 3'd0;
         lane_q     <= 2'd0;
         rd_wa_q    <= 5'd0;
         ld_valid_q <= 1'b0;
         bus_err_q  <= 1'b0;
         ld_data_q  <= 32'd0;
         ld_wa_q    <= 5'd0;
         mem_req_q  <= 1'b0;
         mem_wen_q  <= 1'b1;
         mem_be_q   <= 4'd0;
         mem_addr_q <= '0;
         mem_dout_q <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         ld_valid_q <= 1'b0;
         bus_err_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  is_load_q  <= d_mem_wen_i;
                  lfunct_q   <= lfunct_i;
                  lane_q     <= addr_i[1:0];
                  rd_wa_q    <= rd_wa_i;
                  wait_cnt_q <= 8'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     misalign_q <= 1'b1;
                     state_q    <= S_DONE;
                  end else
`endif
                  begin
                     mem_req_q  <= 1'b1;
                     mem_wen_q  <= d_mem_wen_i;
                     mem_be_q   <= d_mem_wen_i ? 4'b1111 : be_shift;
                     mem_addr_q <= addr_i[ADDR_W+1:2];
                     mem_dout_q <= dout_shift;
                     state_q    <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  if (is_load_q) begin
                     ld_valid_q <= 1'b1;
                     ld_data_q  <= ld_data_d;
                     ld_wa_q    <= rd_wa_q;
                  end
                  state_q <= S_DONE;
               end else if (wait_cnt_q == MAX_WAIT_C) begin
                  mem_req_q <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall_o    = req_i & (state_q != S_DONE);
   assign ld_valid_o = ld_valid_q;
   assign ld_data_o  = ld_data_q;
   assign ld_wa_o    = ld_wa_q;
   assign bus_err_o  = bus_err_q;
   assign mem_req_o  = mem_req_q;
   assign mem_wen_o  = mem_wen_q;
   assign mem_be_o   = mem_be_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_dout_o = mem_dout_q;

endmodule
`default_nettype wire
